mux_rr_stream: RTL and testbench

Parametrised N-to-1 stream multiplexer with valid/ready handshakes on every input and on the output. Each cycle it grants one requesting input, using either fixed priority or round-robin arbitration selected at run time. It registers the selected beat into a single output stage. It generalises the 2:1 combinational mux into a registered, flow-controlled channel selector for shared-bus and datapath merge points.

---
 rtl/mux_rr_stream.sv | 99 +++++++++
 tb/tb_mux_rr_stream.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_stream.sv
// ---------------------------------------------------------------------------
// mux_rr_stream
//   N-to-1 valid/ready stream multiplexer with a single registered output
//   stage. Each cycle one requesting input is granted, by fixed priority
//   (lowest index) or round-robin starting from a rotating pointer,
//   selected at run time by iMode.
//
// Ports
//   iClk    : clock, rising edge
//   iRstN   : asynchronous active-low reset
//   iMode   : 0 = fixed priority, 1 = round-robin
//   iValid  : per-channel request, bit k = channel k
//   iData   : packed channel data, channel k at [k*WIDTH +: WIDTH]
//   oReady  : per-channel accept, one-hot or zero, combinational
//   oValid  : output beat valid (registered)
//   oData   : output beat data (registered)
//   oSel    : index of the channel that produced the output beat (registered)
//   iReady  : downstream accept
// ---------------------------------------------------------------------------
module mux_rr_stream #(
    parameter int NUM_IN = 4,
    parameter int WIDTH  = 8,
    localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    iClk,
    input  logic                    iRstN,
    input  logic                    iMode,
    input  logic [NUM_IN-1:0]       iValid,
    input  logic [NUM_IN*WIDTH-1:0] iData,
    output logic [NUM_IN-1:0]       oReady,
    output logic                    oValid,
    output logic [WIDTH-1:0]        oData,
    output logic [SEL_W-1:0]        oSel,
    input  logic                    iReady
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] grant;
    logic [SEL_W-1:0] lo_idx;
    logic [SEL_W-1:0] hi_idx;
    logic             any_req;
    logic             hi_found;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] chan_data [NUM_IN];

    for (genvar k = 0; k < NUM_IN; k++) begin : g_unpack
        assign chan_data[k] = iData[k*WIDTH +: WIDTH];
    end

    // Round-robin is done as two searches instead of a rotate: the first
    // requester at or above ptr wins; if there is none, the search wraps,
    // which is simply the lowest requester overall. That lowest requester
    // is also the fixed-priority winner, so both modes share one scan.
    always_comb begin
        lo_idx   = '0;
        hi_idx   = '0;
        any_req  = 1'b0;
        hi_found = 1'b0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (iValid[k] && !any_req) begin
                lo_idx  = SEL_W'(k);
                any_req = 1'b1;
            end
            if (iValid[k] && !hi_found && (k >= 32'(ptr))) begin
                hi_idx   = SEL_W'(k);
                hi_found = 1'b1;
            end
        end
    end

    assign grant   = (iMode && hi_found) ? hi_idx : lo_idx;
    assign load_en = !oValid || iReady;
    // Gating with iRstN keeps oReady quiet while reset is held, when the
    // empty output stage would otherwise advertise a load.
    assign xfer    = iRstN && load_en && any_req;
    assign oReady  = xfer ? (NUM_IN'(1) << grant) : '0;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            oValid <= 1'b0;
            oData  <= '0;
            oSel   <= '0;
            ptr    <= '0;
        end else if (load_en) begin
            if (any_req) begin
                oValid <= 1'b1;
                oData  <= chan_data[grant];
                oSel   <= grant;
                if (iMode) begin
                    ptr <= (grant == SEL_W'(NUM_IN - 1)) ? '0 : grant + SEL_W'(1);
                end
            end else begin
                oValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_stream.sv
// ---------------------------------------------------------------------------
// tb_mux_rr_stream
//   Self-checking bench for mux_rr_stream (NUM_IN=4, WIDTH=8): directed
//   scenarios followed by randomized traffic, all compared against a
//   transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_mux_rr_stream;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         mode;
    logic [N-1:0] valid;
    logic [N*W-1:0] data;
    logic [N-1:0] ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   out_sel;
    logic         out_ready;

    logic [W-1:0] dat [N];

    assign data = {dat[3], dat[2], dat[1], dat[0]};

    mux_rr_stream #(.NUM_IN(N), .WIDTH(W)) dut (
        .iClk   (clk),
        .iRstN  (rst_n),
        .iMode  (mode),
        .iValid (valid),
        .iData  (data),
        .oReady (ready),
        .oValid (out_valid),
        .oData  (out_data),
        .oSel   (out_sel),
        .iReady (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit       m_valid;
    bit [7:0] m_data;
    int       m_sel;
    int       m_ptr;
    bit [3:0] last_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_data  = '0;
        m_sel   = 0;
        m_ptr   = 0;
    endtask

    // Winner = first requester in search order; round-robin order starts at
    // ptr and wraps modulo N, fixed order starts at 0.
    function automatic int find_grant(input bit [3:0] v, input bit md, input int p);
        for (int i = 0; i < N; i++) begin
            int k;
            k = md ? (p + i) % N : i;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    // One clock: inputs must already be driven. Checks oReady before the
    // edge, advances the model at the edge and checks outputs after it.
    task automatic cycle();
        int       g;
        bit       load;
        bit [3:0] exp_rdy;
        @(negedge clk);
        load    = !m_valid || out_ready;
        g       = find_grant(valid, mode, m_ptr);
        exp_rdy = (load && g >= 0) ? 4'(1 << g) : 4'b0000;
        check("ready", 32'(ready), 32'(exp_rdy));
        last_ready = exp_rdy;
        @(posedge clk);
        if (load) begin
            if (g >= 0) begin
                m_valid = 1;
                m_data  = dat[g];
                m_sel   = g;
                if (mode) m_ptr = (g + 1) % N;
            end else begin
                m_valid = 0;
            end
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data",  32'(out_data),  32'(m_data));
        check("out_sel",   32'(out_sel),   32'(m_sel));
    endtask

    initial begin
        int exp_seq [5];
        exp_seq = '{1, 2, 3, 0, 1};

        // ---------------- reset with everything requesting ----------------
        rst_n     = 1'b0;
        mode      = 1'b1;
        valid     = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < N; k++) dat[k] = 8'(8'h10 + k);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready),     32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data",  32'(out_data),  32'h0);
        check("rst_sel",   32'(out_sel),   32'h0);
        rst_n = 1'b1;
        cycle();
        check("rel_sel",  32'(out_sel),  32'h0);
        check("rel_data", 32'(out_data), 32'h10);

        // ---------------- round-robin fairness ----------------
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("rr_sel",  32'(out_sel),  32'(exp_seq[i]));
            check("rr_data", 32'(out_data), 32'(8'h10 + exp_seq[i]));
        end
        valid = 4'b1001;
        cycle();
        check("rr_wrap_a", 32'(out_sel), 32'd3);
        cycle();
        check("rr_wrap_b", 32'(out_sel), 32'd0);

        // ---------------- single requester ----------------
        mode   = 1'b0;
        valid  = 4'b0100;
        dat[2] = 8'hA5;
        #1;
        check("single_ready", 32'(ready), 32'b0100);
        cycle();
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_data",  32'(out_data),  32'hA5);
        check("single_sel",   32'(out_sel),   32'd2);
        valid = 4'b0000;
        cycle();
        check("single_drain", 32'(out_valid), 32'd0);

        // move ptr to 2 with one round-robin grant to channel 1
        dat[2] = 8'h12;
        mode   = 1'b1;
        valid  = 4'b0010;
        cycle();

        // ---------------- fixed priority then back to round-robin ----------------
        mode  = 1'b0;
        valid = 4'b1110;
        repeat (3) begin
            cycle();
            check("fixed_sel",      32'(out_sel), 32'd1);
            check("fixed_no_hi_rdy", 32'(last_ready[3:2]), 32'd0);
        end
        mode = 1'b1;
        cycle();
        check("resume_a", 32'(out_sel), 32'd2);
        cycle();
        check("resume_b", 32'(out_sel), 32'd3);
        cycle();
        check("resume_c", 32'(out_sel), 32'd1);

        // ---------------- backpressure ----------------
        valid = 4'b1111;
        cycle();
        check("bp_load", 32'(out_data), 32'h12);
        out_ready = 1'b0;
        repeat (5) begin
            cycle();
            check("bp_ready", 32'(ready),    32'h0);
            check("bp_data",  32'(out_data), 32'h12);
            check("bp_sel",   32'(out_sel),  32'd2);
        end
        out_ready = 1'b1;
        cycle();
        check("bp_resume_valid", 32'(out_valid), 32'd1);
        check("bp_resume_data",  32'(out_data),  32'h13);

        // ---------------- asynchronous reset mid-stream ----------------
        valid = 4'b0100;
        cycle();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", 32'(out_valid), 32'd0);
        check("async_ready", 32'(ready),     32'd0);
        model_reset();
        @(posedge clk);
        #1;
        valid = 4'b1111;
        mode  = 1'b1;
        rst_n = 1'b1;
        cycle();
        check("post_rst_sel", 32'(out_sel), 32'd0);

        // ---------------- randomized traffic ----------------
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                // a pending request must stay put until accepted
                if (!valid[k] || last_ready[k]) begin
                    valid[k] = ($urandom_range(0, 99) < 55);
                    dat[k]   = 8'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
